// File: rtl/issue_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : issue_sched_if
//  Description : Fetch-to-decode issue bus between instruction memory and the
//                issue scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface issue_sched_if #(
    parameter int unsigned ISIZE = 16
);
    logic [ISIZE-1:0] instr_in;
    logic             stall_ext;
    logic [ISIZE-1:0] issue_instr;
    logic             issue_valid;
    logic             pc_en;
    logic [15:0]      bubble_cnt;

    // Fetch side: presents words and the memory-busy freeze.
    modport master (
        output instr_in,
        output stall_ext,
        input  issue_instr,
        input  issue_valid,
        input  pc_en,
        input  bubble_cnt
    );

    // Scheduler side.
    modport slave (
        input  instr_in,
        input  stall_ext,
        output issue_instr,
        output issue_valid,
        output pc_en,
        output bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/issue_sched.sv
`default_nettype none
// ============================================================================
//  Module      : issue_sched
//  Description : Issue scheduler: forwards fetched words or inserts NOP
//                bubbles for load-use, control-transfer and EXEC cases.
//                Optional bubble statistics counter: ISSUE_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_sched #(
    parameter int unsigned    ISIZE      = 16,
    parameter logic [ISIZE-1:0] NOP      = 16'h7000,
    parameter int unsigned    LD_BUBBLES = 1,
    parameter int unsigned    BR_BUBBLES = 2,
    parameter logic [3:0]     EXEC_OP    = 4'hA
) (
    input  wire logic    clk,
    input  wire logic    rst,
    issue_sched_if.slave bus
);

    localparam logic [1:0] c_RUN      = 2'd0;
    localparam logic [1:0] c_LD_HOLD  = 2'd1;
    localparam logic [1:0] c_BR_DRAIN = 2'd2;
    localparam logic [1:0] c_EXEC_GAP = 2'd3;

    localparam logic [1:0] c_LD_LOAD  = 2'(LD_BUBBLES - 1);
    localparam logic [1:0] c_BR_LOAD  = 2'(BR_BUBBLES);

    logic [1:0]       r_state;
    logic [1:0]       r_cnt;
    logic [7:0]       r_last_hi;
    logic             r_resume;
    logic [ISIZE-1:0] r_issue_instr;
    logic             r_issue_valid;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_cnt_nxt;
    logic [7:0]       w_last_hi_nxt;
    logic             w_resume_nxt;
    logic [ISIZE-1:0] w_instr_nxt;
    logic             w_valid_nxt;
    logic             w_pc_en;

    logic [7:0]       w_last_eff;
    logic [3:0]       w_op;
    logic             w_hazard;
    logic             w_ctrl;
    logic             w_exec;

    // Only the opcode and destination field of the last word matter; the
    // first RUN cycle after a load-use hold sees it as NOP so it cannot re-fire.
    assign w_last_eff = r_resume ? NOP[15:8] : r_last_hi;
    assign w_op       = bus.instr_in[15:12];

    assign w_hazard = (w_last_eff[7:4] == 4'b1000) && (
            ((w_last_eff[3:0] == bus.instr_in[7:4])  && (w_op < 4'd10) && (bus.instr_in[7:4]  != 4'd0)) ||
            ((w_last_eff[3:0] == bus.instr_in[3:0])  && (w_op < 4'd5)  && (bus.instr_in[3:0]  != 4'd0)) ||
            ((w_last_eff[3:0] == bus.instr_in[11:8]) && (w_op > 4'd13) && (bus.instr_in[11:8] != 4'd0)));

    assign w_ctrl = (bus.instr_in[15:14] == 2'b11);
    assign w_exec = (w_op == EXEC_OP);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_last_hi_nxt = r_last_hi;
        w_resume_nxt  = r_resume;
        w_instr_nxt   = NOP;
        w_valid_nxt   = 1'b0;
        w_pc_en       = 1'b0;

        case (r_state)
            c_RUN: begin
                w_resume_nxt = 1'b0;
                if (r_resume) begin
                    w_last_hi_nxt = NOP[15:8];
                end
                if (w_hazard) begin
                    w_cnt_nxt = c_LD_LOAD;
                    if (c_LD_LOAD == 2'd0) begin
                        w_resume_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_LD_HOLD;
                    end
                end else begin
                    w_instr_nxt = bus.instr_in;
                    w_valid_nxt = 1'b1;
                    if (bus.instr_in != NOP) begin
                        w_last_hi_nxt = bus.instr_in[15:8];
                    end
                    if (w_ctrl) begin
                        w_cnt_nxt   = c_BR_LOAD;
                        w_state_nxt = c_BR_DRAIN;
                    end else begin
                        w_pc_en = 1'b1;
                        if (w_exec) begin
                            w_state_nxt = c_EXEC_GAP;
                        end
                    end
                end
            end

            c_LD_HOLD: begin
                w_cnt_nxt = r_cnt - 2'd1;
                if (r_cnt <= 2'd1) begin
                    w_state_nxt  = c_RUN;
                    w_resume_nxt = 1'b1;
                end
            end

            c_BR_DRAIN: begin
                w_cnt_nxt = r_cnt - 2'd1;
                // Last drain bubble lets the redirected PC load.
                if (r_cnt <= 2'd1) begin
                    w_pc_en     = 1'b1;
                    w_state_nxt = c_RUN;
                end
            end

            c_EXEC_GAP: begin
                w_state_nxt = c_RUN;
            end

            default: begin
                w_state_nxt = c_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_RUN;
            r_cnt         <= 2'd0;
            r_last_hi     <= NOP[15:8];
            r_resume      <= 1'b0;
            r_issue_instr <= NOP;
            r_issue_valid <= 1'b0;
        end else if (!bus.stall_ext) begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_last_hi     <= w_last_hi_nxt;
            r_resume      <= w_resume_nxt;
            r_issue_instr <= w_instr_nxt;
            r_issue_valid <= w_valid_nxt;
        end
    end

    assign bus.issue_instr = r_issue_instr;
    assign bus.issue_valid = r_issue_valid;
    assign bus.pc_en       = w_pc_en & ~rst & ~bus.stall_ext;

`ifdef ISSUE_STATS_EN
    logic        w_bubble;
    logic [15:0] r_bubble_cnt;

    // Every non-RUN state issues a bubble; in RUN only a hazard does.
    assign w_bubble = (r_state != c_RUN) || w_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= 16'h0000;
        end else if (!bus.stall_ext && w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bus.bubble_cnt = r_bubble_cnt;
`else
    assign bus.bubble_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_sched
//  Description : Directed self-checking bench for issue_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_sched;

`ifdef ISSUE_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] instr;
        logic        valid;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];

    issue_sched_if #(.ISIZE(16)) bus ();

    issue_sched #(
        .ISIZE      (16),
        .NOP        (16'h7000),
        .LD_BUBBLES (1),
        .BR_BUBBLES (2),
        .EXEC_OP    (4'hA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: drive at negedge, check pc_en, push expected issue, pop after edge.
    task automatic cycle(input string tag, input logic r, input logic [15:0] w, input logic s,
                         input logic epc, input logic [15:0] ei, input logic ev);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.instr_in  = w;
        bus.stall_ext = s;
        #1;
        chk({tag, "/pc_en"}, 32'(bus.pc_en), 32'(epc));
        sb.push_back('{instr: ei, valid: ev});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "/sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "/issue_instr"}, 32'(bus.issue_instr), 32'(e.instr));
            chk({tag, "/issue_valid"}, 32'(bus.issue_valid), 32'(e.valid));
        end
    endtask

    task automatic chk_bubbles(input string tag, input int n);
        chk(tag, 32'(bus.bubble_cnt), c_STATS ? 32'(n) : 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.instr_in  = 16'h1111;
        bus.stall_ext = 1'b0;

        // Reset state
        cycle("rst0", 1'b1, 16'h1111, 1'b0, 1'b0, 16'h7000, 1'b0);
        cycle("rst1", 1'b1, 16'h1111, 1'b0, 1'b0, 16'h7000, 1'b0);
        chk_bubbles("rst_bubbles", 0);

        // Load then dependent word
        cycle("ld_dep0", 1'b0, 16'h8300, 1'b0, 1'b1, 16'h8300, 1'b1);
        cycle("ld_dep1", 1'b0, 16'h1034, 1'b0, 1'b0, 16'h7000, 1'b0);
        cycle("ld_dep2", 1'b0, 16'h1034, 1'b0, 1'b1, 16'h1034, 1'b1);
        chk_bubbles("ld_dep_bubbles", 1);

        // Independent words and r0
        cycle("ld_ind0", 1'b0, 16'h8300, 1'b0, 1'b1, 16'h8300, 1'b1);
        cycle("ld_ind1", 1'b0, 16'h1045, 1'b0, 1'b1, 16'h1045, 1'b1);
        cycle("ld_r0_0", 1'b0, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1);
        cycle("ld_r0_1", 1'b0, 16'h1000, 1'b0, 1'b1, 16'h1000, 1'b1);

        // [3:0] field: opcode 5 is outside the range, opcode 4 inside
        cycle("ld_op5_0", 1'b0, 16'h8300, 1'b0, 1'b1, 16'h8300, 1'b1);
        cycle("ld_op5_1", 1'b0, 16'h5013, 1'b0, 1'b1, 16'h5013, 1'b1);
        cycle("ld_op4_0", 1'b0, 16'h8300, 1'b0, 1'b1, 16'h8300, 1'b1);
        cycle("ld_op4_1", 1'b0, 16'h4013, 1'b0, 1'b0, 16'h7000, 1'b0);
        cycle("ld_op4_2", 1'b0, 16'h4013, 1'b0, 1'b1, 16'h4013, 1'b1);

        // Hazard and control transfer in the same word: hold, then drain
        cycle("ld_br0", 1'b0, 16'h8300, 1'b0, 1'b1, 16'h8300, 1'b1);
        cycle("ld_br1", 1'b0, 16'hE300, 1'b0, 1'b0, 16'h7000, 1'b0);
        cycle("ld_br2", 1'b0, 16'hE300, 1'b0, 1'b0, 16'hE300, 1'b1);
        cycle("ld_br3", 1'b0, 16'hE300, 1'b0, 1'b0, 16'h7000, 1'b0);
        cycle("ld_br4", 1'b0, 16'hE300, 1'b0, 1'b1, 16'h7000, 1'b0);
        cycle("ld_br5", 1'b0, 16'h2000, 1'b0, 1'b1, 16'h2000, 1'b1);

        // Control transfer
        cycle("br0", 1'b0, 16'hC010, 1'b0, 1'b0, 16'hC010, 1'b1);
        cycle("br1", 1'b0, 16'hC010, 1'b0, 1'b0, 16'h7000, 1'b0);
        cycle("br2", 1'b0, 16'hC010, 1'b0, 1'b1, 16'h7000, 1'b0);
        cycle("br3", 1'b0, 16'h3000, 1'b0, 1'b1, 16'h3000, 1'b1);

        // EXEC followed by a control transfer word
        cycle("ex0", 1'b0, 16'hA123, 1'b0, 1'b1, 16'hA123, 1'b1);
        cycle("ex1", 1'b0, 16'hC010, 1'b0, 1'b0, 16'h7000, 1'b0);
        cycle("ex2", 1'b0, 16'hC010, 1'b0, 1'b0, 16'hC010, 1'b1);
        cycle("ex3", 1'b0, 16'hC010, 1'b0, 1'b0, 16'h7000, 1'b0);
        cycle("ex4", 1'b0, 16'hC010, 1'b0, 1'b1, 16'h7000, 1'b0);
        cycle("ex5", 1'b0, 16'h3000, 1'b0, 1'b1, 16'h3000, 1'b1);

        // Freeze in the last drain cycle: pc_en held low, outputs held
        cycle("fz0", 1'b0, 16'hC010, 1'b0, 1'b0, 16'hC010, 1'b1);
        cycle("fz1", 1'b0, 16'hC010, 1'b0, 1'b0, 16'h7000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("fz_hold", 1'b0, 16'hC010, 1'b1, 1'b0, 16'h7000, 1'b0);
        end
        cycle("fz2", 1'b0, 16'hC010, 1'b0, 1'b1, 16'h7000, 1'b0);
        cycle("fz3", 1'b0, 16'h3000, 1'b0, 1'b1, 16'h3000, 1'b1);

        // Freeze between a load and its dependent word keeps the load
        cycle("fzld0", 1'b0, 16'h8300, 1'b0, 1'b1, 16'h8300, 1'b1);
        cycle("fzld1", 1'b0, 16'h1034, 1'b1, 1'b0, 16'h8300, 1'b1);
        cycle("fzld2", 1'b0, 16'h1034, 1'b0, 1'b0, 16'h7000, 1'b0);
        cycle("fzld3", 1'b0, 16'h1034, 1'b0, 1'b1, 16'h1034, 1'b1);
        chk_bubbles("total_bubbles", 13);

        // Reset in the middle of a drain
        cycle("rd0", 1'b0, 16'hC010, 1'b0, 1'b0, 16'hC010, 1'b1);
        cycle("rd1", 1'b0, 16'hC010, 1'b0, 1'b0, 16'h7000, 1'b0);
        cycle("rd2", 1'b1, 16'hC010, 1'b0, 1'b0, 16'h7000, 1'b0);
        chk_bubbles("rd_bubbles", 0);
        cycle("rd3", 1'b0, 16'h5555, 1'b0, 1'b1, 16'h5555, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
